// File: rtl/cs_classify_if.sv
// Downstream triangle handshake (valid/ready) for cs_classify.
// Triangle3D is packed {p.x,p.y,p.z,q.x,q.y,q.z,r.x,r.y,r.z}, with p.x in the MSBs.
interface cs_classify_if #(
  parameter int COORD_W = 16
);
  logic [9*COORD_W-1:0] tri_out;
  logic [1:0]           tri_class;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output tri_out, tri_class, out_valid, input out_ready);
  modport slave  (input tri_out, tri_class, out_valid, output out_ready);
endinterface

// File: rtl/cs_classify.sv
// Pops triangles from cs_stack, classifies them against the view box as ACCEPT/CLIP/REJECT,
// forwards ACCEPT/CLIP downstream and counts REJECTs. Optional macro: CS_CLASSIFY_STATS_EN.
module cs_classify #(
  parameter int COORD_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic                       stk_empty,
  input  logic [9*COORD_W-1:0]       stk_tri,
  output logic                       stk_pop,
  input  logic signed [COORD_W-1:0]  xmin,
  input  logic signed [COORD_W-1:0]  xmax,
  input  logic signed [COORD_W-1:0]  ymin,
  input  logic signed [COORD_W-1:0]  ymax,
  input  logic signed [COORD_W-1:0]  zmin,
  input  logic signed [COORD_W-1:0]  zmax,
  cs_classify_if.master              dn,
  output logic [CNT_W-1:0]           reject_cnt,
  output logic [CNT_W-1:0]           accept_cnt,
  output logic [CNT_W-1:0]           clip_cnt,
  output logic                       busy
);

  localparam int TRI_W = 9*COORD_W;
  localparam int VTX_W = 3*COORD_W;

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_CAPTURE, S_CLASSIFY, S_SEND
  } state_t;

  state_t            state_q;
  logic              pop_q, valid_q, busy_q;
  logic [TRI_W-1:0]  tri_q, tri_out_q;
  logic [1:0]        class_q;
  logic [5:0]        oc_p_q, oc_q_q, oc_r_q;
  logic [CNT_W-1:0]  rej_q;
  logic              pop_go;
  logic              handshake;

  // Outcode bits {x<xmin, x>xmax, y<ymin, y>ymax, z<zmin, z>zmax}; equality is inside.
  function automatic logic [5:0] outcode(input logic [VTX_W-1:0] v);
    logic signed [COORD_W-1:0] x, y, z;
    x = v[VTX_W-1 -: COORD_W];
    y = v[2*COORD_W-1 -: COORD_W];
    z = v[COORD_W-1:0];
    return {x < xmin, x > xmax, y < ymin, y > ymax, z < zmin, z > zmax};
  endfunction

  assign pop_go    = run & ~stk_empty;
  assign handshake = (state_q == S_SEND) & valid_q & dn.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pop_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      tri_q     <= '0;
      tri_out_q <= '0;
      class_q   <= 2'b00;
      oc_p_q    <= '0;
      oc_q_q    <= '0;
      oc_r_q    <= '0;
      rej_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop_go) begin
            state_q <= S_POP;
            pop_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_POP: begin
          pop_q   <= 1'b0;
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          tri_q   <= stk_tri;
          oc_p_q  <= outcode(stk_tri[TRI_W-1 -: VTX_W]);
          oc_q_q  <= outcode(stk_tri[2*VTX_W-1 -: VTX_W]);
          oc_r_q  <= outcode(stk_tri[VTX_W-1:0]);
          state_q <= S_CLASSIFY;
        end
        S_CLASSIFY: begin
          if (|(oc_p_q & oc_q_q & oc_r_q)) begin
            if (~&rej_q) rej_q <= rej_q + CNT_W'(1);
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            tri_out_q <= tri_q;
            class_q   <= (|(oc_p_q | oc_q_q | oc_r_q)) ? 2'b10 : 2'b01;
            valid_q   <= 1'b1;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          if (dn.out_ready) begin
            valid_q <= 1'b0;
            class_q <= 2'b00;
            if (pop_go) begin
              state_q <= S_POP;
              pop_q   <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          pop_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          class_q <= 2'b00;
        end
      endcase
    end
  end

  assign stk_pop      = pop_q;
  assign busy         = busy_q;
  assign reject_cnt   = rej_q;
  assign dn.tri_out   = tri_out_q;
  assign dn.tri_class = class_q;
  assign dn.out_valid = valid_q;

`ifdef CS_CLASSIFY_STATS_EN
  logic [CNT_W-1:0] acc_q, clip_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      clip_q <= '0;
    end else if (handshake) begin
      if (class_q == 2'b01) begin
        if (~&acc_q) acc_q <= acc_q + CNT_W'(1);
      end else begin
        if (~&clip_q) clip_q <= clip_q + CNT_W'(1);
      end
    end
  end

  assign accept_cnt = acc_q;
  assign clip_cnt   = clip_q;
`else
  assign accept_cnt = '0;
  assign clip_cnt   = '0;
`endif

endmodule

// File: tb/tb_cs_classify.sv
// Scoreboard bench for cs_classify: a LIFO stack model feeds the DUT, a reference
// classifier predicts each popped triangle, and a monitor checks every output handshake.
module tb_cs_classify;

  localparam int W  = 16;
  localparam int CW = 16;
  localparam int TW = 9*W;

  typedef logic [TW-1:0] tri_t;
  typedef struct {
    tri_t       t;
    logic [1:0] cls;
    int         pcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, run, stk_empty, stk_pop, busy;
  tri_t stk_tri;
  logic signed [W-1:0] xmin, xmax, ymin, ymax, zmin, zmax;
  logic [CW-1:0] reject_cnt, accept_cnt, clip_cnt;

  cs_classify_if #(.COORD_W(W)) dn_if ();

  cs_classify #(.COORD_W(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .stk_empty  (stk_empty),
    .stk_tri    (stk_tri),
    .stk_pop    (stk_pop),
    .xmin       (xmin),
    .xmax       (xmax),
    .ymin       (ymin),
    .ymax       (ymax),
    .zmin       (zmin),
    .zmax       (zmax),
    .dn         (dn_if),
    .reject_cnt (reject_cnt),
    .accept_cnt (accept_cnt),
    .clip_cnt   (clip_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  int   cyc = 0;
  tri_t stack[$];
  tri_t push_req[$];
  tri_t seen[$];
  exp_t sb[$];
  int   exp_rej = 0, exp_acc = 0, exp_clip = 0;
  logic rand_ready = 1'b0, ready_req = 1'b1;
  int   bnd[6] = '{-100, 100, -100, 100, -100, 100};

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic tri_t mk(input int px, py, pz, qx, qy, qz, rx, ry, rz);
    int c[9];
    tri_t t;
    c = '{px, py, pz, qx, qy, qz, rx, ry, rz};
    for (int i = 0; i < 9; i++) t[(8-i)*W +: W] = W'(c[i]);
    return t;
  endfunction

  function automatic int coord(input tri_t t, input int i);
    return int'($signed(t[(8-i)*W +: W]));
  endfunction

  // 0 = reject, 1 = accept, 2 = clip: reject if all three vertices lie beyond the same plane.
  function automatic int ref_class(input tri_t t);
    bit any_out = 0, rej = 0;
    for (int a = 0; a < 3; a++) begin
      for (int s = 0; s < 2; s++) begin
        int n = 0;
        for (int v = 0; v < 3; v++) begin
          int val = coord(t, 3*v + a);
          if (s == 0 ? (val < bnd[2*a]) : (val > bnd[2*a+1])) n++;
        end
        if (n == 3) rej = 1;
        if (n > 0) any_out = 1;
      end
    end
    return rej ? 0 : (any_out ? 2 : 1);
  endfunction

  task automatic set_bounds();
    xmin = W'(bnd[0]); xmax = W'(bnd[1]);
    ymin = W'(bnd[2]); ymax = W'(bnd[3]);
    zmin = W'(bnd[4]); zmax = W'(bnd[5]);
  endtask

  // Stack model and ready driver: acts 1 time unit after each rising edge.
  initial begin
    stk_empty = 1'b1;
    stk_tri   = '0;
    dn_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        stack.delete();
        push_req.delete();
        exp_rej = 0;
      end else if (stk_pop) begin
        check("pop_nonempty", 144'(stack.size() != 0), 144'(1));
        check("pop_no_valid", 144'(dn_if.out_valid), 144'(0));
        if (stack.size() != 0) begin
          tri_t t;
          int   c;
          t = stack.pop_back();
          stk_tri = t;
          c = ref_class(t);
          if (c == 0) exp_rej++;
          else sb.push_back('{t, 2'(c), cyc});
        end
      end
      while (push_req.size() != 0) stack.push_back(push_req.pop_front());
      stk_empty = (stack.size() == 0);
      dn_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_req;
    end
  end

  // Monitor: samples on the falling edge.
  initial begin
    logic       pv = 1'b0, pr = 1'b0;
    tri_t       pt = '0;
    logic [1:0] pc = 2'b00;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        exp_acc = 0;
        exp_clip = 0;
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        check("stall_valid", 144'(dn_if.out_valid), 144'(1));
        check("stall_tri", dn_if.tri_out, pt);
        check("stall_class", 144'(dn_if.tri_class), 144'(pc));
      end
      if (dn_if.out_valid && !pv && sb.size() != 0)
        check("latency", 144'(cyc - sb[0].pcyc), 144'(3));
      if (!dn_if.out_valid)
        check("class_idle", 144'(dn_if.tri_class), 144'(0));
      if (dn_if.out_valid && dn_if.out_ready) begin
        seen.push_back(dn_if.tri_out);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h with class %0d, required none", dn_if.tri_out, dn_if.tri_class);
        end else begin
          e = sb.pop_front();
          check("out_tri", dn_if.tri_out, e.t);
          check("out_class", 144'(dn_if.tri_class), 144'(e.cls));
          if (e.cls == 2'b01) exp_acc++;
          else exp_clip++;
        end
      end
      pv = dn_if.out_valid;
      pr = dn_if.out_ready;
      pt = dn_if.tri_out;
      pc = dn_if.tri_class;
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((stack.size() != 0 || push_req.size() != 0 || busy) && n < 3000) begin
      @(posedge clk); #2; n++;
    end
    check({name, "_timeout"}, 144'(n < 3000), 144'(1));
    @(posedge clk); #2;
    check({name, "_sb_empty"}, 144'(sb.size()), 144'(0));
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!dn_if.out_valid && n < 200) begin
      @(posedge clk); #2; n++;
    end
    check({name, "_valid_timeout"}, 144'(n < 200), 144'(1));
  endtask

  task automatic check_stats(input string name, input int acc, input int clp);
`ifdef CS_CLASSIFY_STATS_EN
    check({name, "_accept_cnt"}, 144'(accept_cnt), 144'(acc));
    check({name, "_clip_cnt"}, 144'(clip_cnt), 144'(clp));
`else
    check({name, "_accept_cnt"}, 144'(accept_cnt), 144'(0));
    check({name, "_clip_cnt"}, 144'(clip_cnt), 144'(0));
    if (acc < 0 || clp < 0) $display("negative stats request");
`endif
  endtask

  function automatic int pick(input int lo, input int hi);
    case ($urandom_range(0, 5))
      0: return lo;
      1: return hi;
      2: return lo - 1;
      3: return hi + 1;
      default: return int'($urandom_range(0, 400)) - 200;
    endcase
  endfunction

  initial begin
    tri_t ta, tb, tc;
    int   base, nb;
    rst = 1'b1;
    run = 1'b0;
    set_bounds();
    repeat (3) @(posedge clk);
    #2;
    check("rst_pop", 144'(stk_pop), 144'(0));
    check("rst_valid", 144'(dn_if.out_valid), 144'(0));
    check("rst_busy", 144'(busy), 144'(0));
    check("rst_tri", dn_if.tri_out, '0);
    check("rst_class", 144'(dn_if.tri_class), 144'(0));
    check("rst_reject", 144'(reject_cnt), 144'(0));
    check_stats("rst", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;

    // Basic accept, all-outside reject, clip, and inclusive-bound accept.
    run = 1'b1;
    push_req.push_back(mk(11, 22, 33, 1, 2, 4, 8, 6, 7));
    wait_drain("t1");
    check("t1_handshakes", 144'(seen.size()), 144'(1));
    push_req.push_back(mk(150, 0, 0, 200, 5, 5, 101, -3, 2));
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (busy) nb++;
    end
    check("t2_reject_cnt", 144'(reject_cnt), 144'(1));
    check("t2_busy_cycles", 144'(nb), 144'(3));
    check("t2_no_output", 144'(seen.size()), 144'(1));
    push_req.push_back(mk(0, 0, 0, 150, 0, 0, 0, 50, 0));
    wait_drain("t3a");
    push_req.push_back(mk(100, -100, 0, 0, 0, 100, 5, 5, 5));
    wait_drain("t3b");
    check_stats("t3", 2, 1);

    // LIFO order and a 5-cycle stall on the first output.
    run = 1'b0;
    ready_req = 1'b0;
    ta = mk(1, 1, 1, 2, 2, 2, 3, 3, 3);
    tb = mk(-5, 6, -7, 8, -9, 10, 0, 0, 0);
    tc = mk(90, -90, 90, -90, 90, -90, 0, 1, 2);
    push_req.push_back(ta); push_req.push_back(tb); push_req.push_back(tc);
    repeat (3) @(posedge clk);
    #2;
    base = seen.size();
    run = 1'b1;
    wait_valid("t4");
    repeat (5) @(posedge clk);
    #2;
    check("t4_no_pop_stalled", 144'(stack.size()), 144'(2));
    ready_req = 1'b1;
    wait_drain("t4");
    check("t4_count", 144'(seen.size() - base), 144'(3));
    if (seen.size() >= base + 3) begin
      check("t4_first_C", seen[base], tc);
      check("t4_second_B", seen[base+1], tb);
      check("t4_third_A", seen[base+2], ta);
    end

    // Empty stack with run high, then run dropped during SEND.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      check("t5_empty_pop", 144'(stk_pop), 144'(0));
      check("t5_empty_busy", 144'(busy), 144'(0));
    end
    run = 1'b0;
    ready_req = 1'b0;
    push_req.push_back(ta); push_req.push_back(tb);
    repeat (2) @(posedge clk);
    #2;
    base = seen.size();
    run = 1'b1;
    wait_valid("t5");
    run = 1'b0;
    ready_req = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    check("t5_one_handshake", 144'(seen.size() - base), 144'(1));
    check("t5_no_more_pop", 144'(stack.size()), 144'(1));
    check("t5_idle", 144'(busy), 144'(0));
    run = 1'b1;
    wait_drain("t5");

    // Randomized batches with random view boxes (including inverted ones) and random ready.
    rand_ready = 1'b1;
    for (int b = 0; b < 40; b++) begin
      wait_drain("rnd");
      for (int a = 0; a < 3; a++) begin
        bnd[2*a]   = int'($urandom_range(0, 200)) - 150;
        bnd[2*a+1] = bnd[2*a] + int'($urandom_range(0, 220)) - 20;
      end
      set_bounds();
      for (int k = 0, n = int'($urandom_range(1, 8)); k < n; k++) begin
        int c[9];
        tri_t t;
        for (int i = 0; i < 9; i++) c[i] = pick(bnd[2*(i%3)], bnd[2*(i%3)+1]);
        for (int i = 0; i < 9; i++) t[(8-i)*W +: W] = W'(c[i]);
        push_req.push_back(t);
        repeat ($urandom_range(0, 6)) @(posedge clk);
        #2;
      end
    end
    wait_drain("rnd_end");
    check("rnd_reject_cnt", 144'(reject_cnt), 144'(exp_rej));
    check_stats("rnd", exp_acc, exp_clip);

    // Asynchronous reset while a triangle is waiting in SEND.
    rand_ready = 1'b0;
    ready_req = 1'b0;
    bnd = '{-100, 100, -100, 100, -100, 100};
    set_bounds();
    push_req.push_back(ta);
    wait_valid("t6");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6_valid", 144'(dn_if.out_valid), 144'(0));
    check("t6_busy", 144'(busy), 144'(0));
    check("t6_class", 144'(dn_if.tri_class), 144'(0));
    check("t6_tri", dn_if.tri_out, '0);
    check("t6_reject", 144'(reject_cnt), 144'(0));
    check_stats("t6", 0, 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
